// File: rtl/alu_pkg.sv
// Shared encodings for the operand fetch stage feeding the 8-bit ALU:
// opcodes, ALU select values, instruction field positions and FSM states.
package alu_pkg;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;

  localparam logic [2:0] SEL_FWD = 3'b000;
  localparam logic [2:0] SEL_ADD = 3'b001;
  localparam logic [2:0] SEL_AND = 3'b010;
  localparam logic [2:0] SEL_OR  = 3'b011;

  localparam int unsigned FIELD_W  = 8;
  localparam int unsigned OPC_LSB  = 24;
  localparam int unsigned DEST_LSB = 16;
  localparam int unsigned SRC1_LSB = 8;
  localparam int unsigned SRC2_LSB = 0;
  localparam int unsigned IMM_LSB  = 0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/operand_fetch_stage_reg_file.sv
// Register file: two combinational read ports, one synchronous write port,
// asynchronous active-low clear and an unforwarded debug read port.
module reg_file #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned ADDR_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] mem [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = mem[rd_addr_a];
  assign rd_data_b = mem[rd_addr_b];
  assign dbg_data  = mem[dbg_addr];

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: decodes instruction words, reads/forwards operands and
// registers Data1/Data2/Select into the ALU; writes the ALU result back.
module operand_fetch_stage
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned ADDR_W   = 3
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [31:0]       In_Instr,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic              Hold,
  output logic [DATA_W-1:0] Data1,
  output logic [DATA_W-1:0] Data2,
  output logic [2:0]        Select,
  output logic              Alu_Valid,
  output logic [ADDR_W-1:0] Dest,
  input  logic [DATA_W-1:0] Result,
  output logic              Illegal,
  input  logic [ADDR_W-1:0] Dbg_Addr,
  output logic [DATA_W-1:0] Dbg_Data
);

  fetch_state_t      state;
  logic [7:0]        opcode;
  logic [ADDR_W-1:0] dest_idx, src1_idx, src2_idx;
  logic [DATA_W-1:0] imm, rd_a, rd_b, op_a, op_b, neg_b;
  logic [DATA_W-1:0] nxt_d1, nxt_d2;
  logic [2:0]        nxt_sel;
  logic              legal, accept, wr_en;
  logic              unused_fields;

  assign opcode   = In_Instr[OPC_LSB +: FIELD_W];
  assign dest_idx = In_Instr[DEST_LSB +: ADDR_W];
  assign src1_idx = In_Instr[SRC1_LSB +: ADDR_W];
  assign src2_idx = In_Instr[SRC2_LSB +: ADDR_W];
  assign imm      = In_Instr[IMM_LSB +: DATA_W];
  assign unused_fields = ^{In_Instr[DEST_LSB+ADDR_W +: FIELD_W-ADDR_W],
                           In_Instr[SRC1_LSB+ADDR_W +: FIELD_W-ADDR_W]};

  assign In_Ready  = !Hold;
  assign accept    = In_Valid && !Hold;
  assign Alu_Valid = (state == ST_ISSUE);
  assign wr_en     = Alu_Valid && !Hold;

  reg_file #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_reg_file (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .rd_addr_a (src1_idx),
    .rd_data_a (rd_a),
    .rd_addr_b (src2_idx),
    .rd_data_b (rd_b),
    .wr_en     (wr_en),
    .wr_addr   (Dest),
    .wr_data   (Result),
    .dbg_addr  (Dbg_Addr),
    .dbg_data  (Dbg_Data)
  );

  // The result being written this edge is not yet in the array, so bypass it.
  assign op_a  = (wr_en && (src1_idx == Dest)) ? Result : rd_a;
  assign op_b  = (wr_en && (src2_idx == Dest)) ? Result : rd_b;
  assign neg_b = (~op_b) + DATA_W'(1);

  always_comb begin
    nxt_d1  = '0;
    nxt_d2  = '0;
    nxt_sel = SEL_FWD;
    legal   = 1'b1;
    case (opcode)
      OP_LOADI: nxt_d1 = imm;
      OP_MOV:   nxt_d1 = op_b;
      OP_ADD: begin
        nxt_d1  = op_a;
        nxt_d2  = op_b;
        nxt_sel = SEL_ADD;
      end
      OP_SUB: begin
        nxt_d1  = op_a;
        nxt_d2  = neg_b;
        nxt_sel = SEL_ADD;
      end
      OP_AND: begin
        nxt_d1  = op_a;
        nxt_d2  = op_b;
        nxt_sel = SEL_AND;
      end
      OP_OR: begin
        nxt_d1  = op_a;
        nxt_d2  = op_b;
        nxt_sel = SEL_OR;
      end
      default: legal = 1'b0;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= ST_IDLE;
      Data1   <= '0;
      Data2   <= '0;
      Select  <= SEL_FWD;
      Dest    <= '0;
      Illegal <= 1'b0;
    end else begin
      Illegal <= accept && !legal;
      if (!Hold) begin
        if (accept && legal) begin
          state  <= ST_ISSUE;
          Data1  <= nxt_d1;
          Data2  <= nxt_d2;
          Select <= nxt_sel;
          Dest   <= dest_idx;
        end else begin
          state <= ST_IDLE;
        end
      end
    end
  end

endmodule
